// File: rtl/instr_mem_loader_if.sv
// Byte-stream program load channel into the instruction memory loader.
// The master drives program bytes; the slave (loader) returns ready.
interface instr_mem_loader_if;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;

    modport master (
        output load_start,
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Writable instruction memory for the core: loads a program over a byte stream,
// holds the core in reset while loading, then serves instructions by pc.
module instr_mem_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter logic [7:0]  FILL   = 8'b11000011
) (
    input  logic                origclk,
    input  logic                reset,
    instr_mem_loader_if.slave   load,
    input  logic [7:0]          pc,
    output logic [7:0]          instruction,
    output logic                cpu_reset,
    output logic [ADDR_W:0]     prog_len,
    output logic                pc_fault
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CMP_W = 9;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] ptr;

    logic hs_c;
    logic last_addr_c;
    logic in_range_c;
    logic run_c;
    logic restart_c;

    assign hs_c        = load.load_valid & load.load_ready;
    assign last_addr_c = (ptr == ADDR_W'(DEPTH - 1));
    assign in_range_c  = (CMP_W'(pc) < CMP_W'(prog_len));
    assign restart_c   = run_c & load.load_start;

    // State register
    always_ff @(posedge origclk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: LOAD exits only on a handshake, so an empty program cannot reach RUN
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (hs_c && (load.load_last || last_addr_c)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (load.load_start) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        load.load_ready = 1'b0;
        cpu_reset       = 1'b1;
        run_c           = 1'b0;
        case (state)
            ST_LOAD: begin
                load.load_ready = 1'b1;
            end
            ST_FLUSH: begin
                cpu_reset = 1'b1;
            end
            ST_RUN: begin
                cpu_reset = 1'b0;
                run_c     = 1'b1;
            end
            default: begin
                cpu_reset = 1'b1;
            end
        endcase
    end

    // Write pointer, program length and sticky out-of-range flag
    always_ff @(posedge origclk) begin
        if (reset) begin
            ptr      <= '0;
            prog_len <= '0;
            pc_fault <= 1'b0;
        end else if (restart_c) begin
            ptr      <= '0;
            prog_len <= '0;
            pc_fault <= 1'b0;
        end else begin
            if (hs_c) begin
                ptr      <= ptr + ADDR_W'(1);
                prog_len <= prog_len + LEN_W'(1);
            end
            if (run_c && !in_range_c) begin
                pc_fault <= 1'b1;
            end
        end
    end

    // Storage is never cleared; prog_len gates what is visible
    always_ff @(posedge origclk) begin
        if (hs_c) begin
            mem[ptr] <= load.load_data;
        end
    end

    // Zero-latency read; full 8-bit pc compare so pc >= DEPTH never aliases
    always_comb begin
        instruction = FILL;
        if (run_c && in_range_c) begin
            instruction = mem[pc[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table-driven read-back per program
// plus hand-written load, flush, restart and reset sequences.
module tb_instr_mem_loader;

    localparam logic [7:0] FILL = 8'hC3;

    typedef struct {
        int         phase;
        logic [7:0] pc;
        logic [7:0] instr;
        logic       fault;
    } vec_t;

    logic       origclk;
    logic       reset;
    logic [7:0] pc;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic [5:0] prog_len;
    logic       pc_fault;

    int n_cmp;
    int n_err;
    vec_t vecs[$];

    instr_mem_loader_if bus ();

    instr_mem_loader #(
        .DEPTH  (32),
        .ADDR_W (5),
        .FILL   (FILL)
    ) dut (
        .origclk     (origclk),
        .reset       (reset),
        .load        (bus),
        .pc          (pc),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .prog_len    (prog_len),
        .pc_fault    (pc_fault)
    );

    initial origclk = 1'b0;
    always #5 origclk = ~origclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge origclk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = 8'hEE;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic run_phase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                pc = vecs[i].pc;
                #1;
                check($sformatf("p%0d_instr_pc%0d", p, vecs[i].pc), 32'(instruction), 32'(vecs[i].instr));
                tick();
                check($sformatf("p%0d_fault_pc%0d", p, vecs[i].pc), 32'(pc_fault), 32'(vecs[i].fault));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Read-back vectors: {phase, pc, expected instruction, expected pc_fault after the edge}
        vecs.push_back('{1, 8'd0,   8'h44, 1'b0});
        vecs.push_back('{1, 8'd1,   8'h49, 1'b0});
        vecs.push_back('{1, 8'd2,   8'h19, 1'b0});
        vecs.push_back('{1, 8'd3,   8'h84, 1'b0});
        vecs.push_back('{1, 8'd4,   FILL,  1'b1});
        vecs.push_back('{1, 8'd3,   8'h84, 1'b1});
        vecs.push_back('{1, 8'hFF,  FILL,  1'b1});
        vecs.push_back('{2, 8'd0,   8'h00, 1'b0});
        vecs.push_back('{2, 8'd17,  8'h11, 1'b0});
        vecs.push_back('{2, 8'd31,  8'h1F, 1'b0});
        vecs.push_back('{2, 8'd32,  FILL,  1'b1});
        vecs.push_back('{2, 8'h80,  FILL,  1'b1});
        vecs.push_back('{3, 8'd0,   8'hA1, 1'b0});
        vecs.push_back('{3, 8'd1,   8'hB2, 1'b0});
        vecs.push_back('{3, 8'd2,   8'h5D, 1'b0});
        vecs.push_back('{3, 8'd3,   FILL,  1'b1});
        vecs.push_back('{4, 8'd0,   8'h3C, 1'b0});
        vecs.push_back('{4, 8'd1,   8'h5A, 1'b0});
        vecs.push_back('{4, 8'd2,   FILL,  1'b1});
        vecs.push_back('{5, 8'd0,   8'hAB, 1'b0});
        vecs.push_back('{5, 8'd1,   FILL,  1'b1});
        vecs.push_back('{6, 8'd0,   8'h11, 1'b0});
        vecs.push_back('{6, 8'd1,   8'h22, 1'b0});
        vecs.push_back('{6, 8'd33,  FILL,  1'b1});

        reset          = 1'b1;
        pc             = 8'd0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.load_last  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst_cpu_reset",  32'(cpu_reset),      32'd1);
        check("rst_prog_len",   32'(prog_len),       32'd0);
        check("rst_pc_fault",   32'(pc_fault),       32'd0);
        check("rst_instr",      32'(instruction),    32'(FILL));

        // Phase 1: four bytes, last on the fourth
        push(8'h44, 1'b0);
        push(8'h49, 1'b0);
        push(8'h19, 1'b0);
        push(8'h84, 1'b1);
        check("p1_flush_ready",  32'(bus.load_ready), 32'd0);
        check("p1_flush_cpurst", 32'(cpu_reset),      32'd1);
        check("p1_prog_len",     32'(prog_len),       32'd4);
        check("p1_flush_instr",  32'(instruction),    32'(FILL));
        tick();
        check("p1_run_cpurst",   32'(cpu_reset),      32'd0);
        check("p1_run_ready",    32'(bus.load_ready), 32'd0);
        run_phase(1);

        // Phase 2: 32 bytes without load_last, auto-exit on the top address
        pulse_start();
        check("p2_restart_len", 32'(prog_len), 32'd0);
        for (int i = 0; i < 31; i++) begin
            push(8'(i), 1'b0);
        end
        check("p2_ready_before_31", 32'(bus.load_ready), 32'd1);
        push(8'd31, 1'b0);
        check("p2_auto_exit_ready", 32'(bus.load_ready), 32'd0);
        check("p2_prog_len",        32'(prog_len),       32'd32);
        tick();
        check("p2_run_cpurst",      32'(cpu_reset),      32'd0);
        run_phase(2);

        // Phase 3: gapped handshake; gap cycles carry junk data and load_last
        pulse_start();
        push(8'hA1, 1'b0);
        bus.load_data = 8'hEE;
        bus.load_last = 1'b1;
        tick();
        push(8'hB2, 1'b0);
        bus.load_data = 8'hEE;
        bus.load_last = 1'b1;
        tick();
        bus.load_last = 1'b0;
        check("p3_still_loading", 32'(bus.load_ready), 32'd1);
        check("p3_len_mid",       32'(prog_len),       32'd2);
        push(8'h5D, 1'b1);
        check("p3_prog_len",      32'(prog_len),       32'd3);
        tick();
        run_phase(3);

        // Phase 4: load_start with load_valid while faulted; byte must be dropped
        check("p4_pre_fault", 32'(pc_fault), 32'd1);
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h77;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        check("p4_ready",    32'(bus.load_ready), 32'd1);
        check("p4_fault_clr",32'(pc_fault),       32'd0);
        check("p4_len_clr",  32'(prog_len),       32'd0);
        check("p4_cpurst",   32'(cpu_reset),      32'd1);
        check("p4_instr",    32'(instruction),    32'(FILL));
        push(8'h3C, 1'b0);
        push(8'h5A, 1'b1);
        check("p4_prog_len", 32'(prog_len), 32'd2);
        tick();
        run_phase(4);

        // Phase 5: reset mid-load with a byte on the bus
        pulse_start();
        push(8'h10, 1'b0);
        push(8'h20, 1'b0);
        reset          = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h30;
        tick();
        reset          = 1'b0;
        bus.load_valid = 1'b0;
        check("p5_rst_ready",  32'(bus.load_ready), 32'd1);
        check("p5_rst_len",    32'(prog_len),       32'd0);
        check("p5_rst_cpurst", 32'(cpu_reset),      32'd1);
        push(8'hAB, 1'b1);
        check("p5_prog_len", 32'(prog_len), 32'd1);
        tick();
        run_phase(5);

        // Phase 6: load_start ignored in LOAD and FLUSH; valid in RUN is a no-op
        pulse_start();
        push(8'h11, 1'b0);
        pulse_start();
        check("p6_load_start_len",   32'(prog_len),       32'd1);
        check("p6_load_start_ready", 32'(bus.load_ready), 32'd1);
        push(8'h22, 1'b1);
        pulse_start();
        check("p6_flush_start_run",  32'(cpu_reset), 32'd0);
        check("p6_flush_start_len",  32'(prog_len),  32'd2);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h99;
        bus.load_last  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("p6_run_valid_len",    32'(prog_len),  32'd2);
        check("p6_run_valid_cpurst", 32'(cpu_reset), 32'd0);
        run_phase(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
